// File: rtl/stump_sequencer.sv
// Stump fetch/execute/memory phase sequencer with memory wait states, timeout bus error and single-step halt.
// Define STUMP_SEQ_PERF_EN to build the cycle/instruction performance counters.
module stump_sequencer #(
  parameter int unsigned MAX_WAIT  = 15,
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mem_ready,
  input  logic                 need_mem,
  input  logic                 is_store,
  input  logic                 step_mode,
  input  logic                 step_req,
  output logic                 fetch,
  output logic                 execute,
  output logic                 memory,
  output logic                 halted,
  output logic                 mem_ren,
  output logic                 mem_wen,
  output logic                 ir_load,
  output logic                 pc_inc,
  output logic                 exec_en,
  output logic                 instr_done,
  output logic                 bus_error,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instr_count
);

  localparam int unsigned WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_EXECUTE = 2'd1,
    S_MEMORY  = 2'd2,
    S_HALT    = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                bus_error_q, bus_error_d;
  logic                timeout;

  // A stalled access times out only once the counter has already spent MAX_WAIT wait cycles.
  assign timeout = (MAX_WAIT != 0) && !mem_ready && (wait_q == WAIT_W'(MAX_WAIT));

  always_comb begin
    state_d     = state_q;
    bus_error_d = bus_error_q;
    fetch       = 1'b0;
    execute     = 1'b0;
    memory      = 1'b0;
    halted      = 1'b0;
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    ir_load     = 1'b0;
    pc_inc      = 1'b0;
    exec_en     = 1'b0;
    instr_done  = 1'b0;
    case (state_q)
      S_FETCH: begin
        fetch   = 1'b1;
        mem_ren = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_EXECUTE;
        end else if (timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_EXECUTE: begin
        execute = 1'b1;
        exec_en = 1'b1;
        if (need_mem) begin
          state_d = S_MEMORY;
        end else begin
          instr_done = 1'b1;
          state_d    = step_mode ? S_HALT : S_FETCH;
        end
      end
      S_MEMORY: begin
        memory  = 1'b1;
        mem_wen = is_store;
        mem_ren = !is_store;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = step_mode ? S_HALT : S_FETCH;
        end else if (timeout) begin
          bus_error_d = 1'b1;
          state_d     = S_HALT;
        end
      end
      S_HALT: begin
        halted = 1'b1;
        if (!bus_error_q && (step_req || !step_mode)) begin
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if (state_d != state_q) begin
      wait_d = '0;
    end else if (state_q == S_FETCH || state_q == S_MEMORY) begin
      wait_d = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      wait_q      <= '0;
      bus_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      bus_error_q <= bus_error_d;
    end
  end

  assign bus_error = bus_error_q;

`ifdef STUMP_SEQ_PERF_EN
  logic [CNT_WIDTH-1:0] cycle_q, cycle_d;
  logic [CNT_WIDTH-1:0] instr_q, instr_d;

  always_comb begin
    cycle_d = cycle_q;
    instr_d = instr_q;
    if (state_q != S_HALT) begin
      cycle_d = cycle_q + 1'b1;
    end
    if (instr_done) begin
      instr_d = instr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  assign cycle_count = cycle_q;
  assign instr_count = instr_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_stump_sequencer.sv
// Self-checking bench for stump_sequencer: instruction-level reference model expands each
// instruction into an expected per-cycle strobe trace, compared against the DUT cycle by cycle.
module tb_stump_sequencer;

  localparam int MAX_WAIT = 3;
  localparam int CW       = 16;

  localparam logic [10:0] B_FETCH = 11'h400;
  localparam logic [10:0] B_EXEC  = 11'h200;
  localparam logic [10:0] B_MEM   = 11'h100;
  localparam logic [10:0] B_HALT  = 11'h080;
  localparam logic [10:0] B_REN   = 11'h040;
  localparam logic [10:0] B_WEN   = 11'h020;
  localparam logic [10:0] B_IRL   = 11'h010;
  localparam logic [10:0] B_PCI   = 11'h008;
  localparam logic [10:0] B_EXE   = 11'h004;
  localparam logic [10:0] B_DONE  = 11'h002;
  localparam logic [10:0] B_BERR  = 11'h001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_ready = 1'b0, need_mem = 1'b0, is_store = 1'b0, step_mode = 1'b0, step_req = 1'b0;
  logic fetch, execute, memory, halted, mem_ren, mem_wen, ir_load, pc_inc, exec_en, instr_done, bus_error;
  logic [CW-1:0] cycle_count, instr_count;

  stump_sequencer #(.MAX_WAIT(MAX_WAIT), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .mem_ready(mem_ready), .need_mem(need_mem), .is_store(is_store),
    .step_mode(step_mode), .step_req(step_req), .fetch(fetch), .execute(execute), .memory(memory),
    .halted(halted), .mem_ren(mem_ren), .mem_wen(mem_wen), .ir_load(ir_load), .pc_inc(pc_inc),
    .exec_en(exec_en), .instr_done(instr_done), .bus_error(bus_error),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, nm, st, sm, sr;
    logic [10:0] exp;
  } cyc_t;

  cyc_t        exp_q[$];
  bit          m_berr;
  int unsigned m_cyc, m_ins;
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic void push(logic rdy, logic nm, logic st, logic sm, logic sr, logic [10:0] e);
    cyc_t c;
    c.rdy = rdy; c.nm = nm; c.st = st; c.sm = sm; c.sr = sr;
    c.exp = e | (m_berr ? B_BERR : 11'h000);
    exp_q.push_back(c);
  endfunction

  // One instruction: fetch with fw wait cycles, execute, optional memory access with mw wait cycles.
  // Returns 0 if the instruction ends in a bus-error timeout.
  function automatic bit model_instr(int fw, bit nm, bit st, int mw, bit sm);
    for (int i = 0; i <= fw; i++) begin
      bit rdy = (i == fw);
      if (!rdy && MAX_WAIT > 0 && i == MAX_WAIT) begin
        push(1'b0, rnd(), rnd(), sm, rnd(), B_FETCH | B_REN);
        m_berr = 1'b1;
        return 1'b0;
      end
      push(rdy, rnd(), rnd(), sm, rnd(), B_FETCH | B_REN | (rdy ? (B_IRL | B_PCI) : 11'h000));
    end
    push(rnd(), nm, rnd(), sm, rnd(), B_EXEC | B_EXE | (nm ? 11'h000 : B_DONE));
    if (!nm) return 1'b1;
    for (int i = 0; i <= mw; i++) begin
      bit rdy = (i == mw);
      logic [10:0] strobe = st ? B_WEN : B_REN;
      if (!rdy && MAX_WAIT > 0 && i == MAX_WAIT) begin
        push(1'b0, rnd(), st, sm, rnd(), B_MEM | strobe);
        m_berr = 1'b1;
        return 1'b0;
      end
      push(rdy, rnd(), st, sm, rnd(), B_MEM | strobe | (rdy ? B_DONE : 11'h000));
    end
    return 1'b1;
  endfunction

  // n HALT cycles; with bus error, step_mode/step_req are random and must not release it.
  function automatic void model_halt(int n, bit release_last);
    for (int i = 0; i < n; i++) begin
      if (m_berr) push(rnd(), rnd(), rnd(), rnd(), rnd(), B_HALT);
      else        push(rnd(), rnd(), rnd(), 1'b1, release_last && (i == n - 1), B_HALT);
    end
  endfunction

  function automatic logic [CW-1:0] exp_cyc();
`ifdef STUMP_SEQ_PERF_EN
    return CW'(m_cyc);
`else
    return '0;
`endif
  endfunction

  function automatic logic [CW-1:0] exp_ins();
`ifdef STUMP_SEQ_PERF_EN
    return CW'(m_ins);
`else
    return '0;
`endif
  endfunction

  task automatic drive_cycle(input cyc_t c, output logic [10:0] obs);
    mem_ready = c.rdy; need_mem = c.nm; is_store = c.st; step_mode = c.sm; step_req = c.sr;
    @(negedge clk);
    obs = {fetch, execute, memory, halted, mem_ren, mem_wen, ir_load, pc_inc, exec_en, instr_done, bus_error};
    if (!c.exp[7]) m_cyc++;
    if (c.exp[1])  m_ins++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = rnd(); need_mem = rnd(); is_store = rnd(); step_mode = rnd(); step_req = rnd();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_berr = 1'b0; m_cyc = 0; m_ins = 0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    cyc_t c;
    do_reset();
    n_checks++;
    if (cycle_count !== '0 || instr_count !== '0)
      $display("FAIL reset_counters: cycle=%0d instr=%0d, required 0/0", cycle_count, instr_count);
    else n_pass++;
    c.rdy = 1'b0; c.nm = 1'b1; c.st = 1'b1; c.sm = 1'b0; c.sr = 1'b1; c.exp = B_FETCH | B_REN;
    drive_cycle(c, obs);
    n_checks++;
    if (obs !== c.exp) $display("FAIL reset_state: got %b required %b", obs, c.exp);
    else n_pass++;
  endtask

  task automatic test_alu_run();
    cyc_t c; logic [10:0] obs; int cyc = 0;
    do_reset();
    repeat (3) void'(model_instr(0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive_cycle(c, obs);
      n_checks++;
      if (obs !== c.exp) $display("FAIL alu_trace cyc%0d: got %b required %b", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (instr_count !== exp_ins() || cycle_count !== exp_cyc() || m_ins != 3 || m_cyc != 6)
      $display("FAIL alu_counts: instr=%0d cycle=%0d required %0d/%0d", instr_count, cycle_count, exp_ins(), exp_cyc());
    else n_pass++;
  endtask

  task automatic test_load_wait();
    cyc_t c; logic [10:0] obs; int cyc = 0;
    do_reset();
    void'(model_instr(0, 1'b1, 1'b0, 2, 1'b0));
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive_cycle(c, obs);
      n_checks++;
      if (obs !== c.exp) $display("FAIL load_wait cyc%0d: got %b required %b", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (cyc != 5 || instr_count !== exp_ins() || cycle_count !== exp_cyc())
      $display("FAIL load_wait_len: cycles=%0d instr=%0d cnt=%0d required 5/%0d/%0d", cyc, instr_count, cycle_count, exp_ins(), exp_cyc());
    else n_pass++;
  endtask

  task automatic test_wait_boundary();
    cyc_t c; logic [10:0] obs; int cyc = 0;
    do_reset();
    void'(model_instr(MAX_WAIT, 1'b1, 1'b1, MAX_WAIT, 1'b0));
    void'(model_instr(MAX_WAIT, 1'b1, 1'b0, MAX_WAIT, 1'b0));
    void'(model_instr(0, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive_cycle(c, obs);
      n_checks++;
      if (obs !== c.exp) $display("FAIL wait_boundary cyc%0d: got %b required %b", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (instr_count !== exp_ins() || cycle_count !== exp_cyc())
      $display("FAIL wait_boundary_counts: instr=%0d cycle=%0d required %0d/%0d", instr_count, cycle_count, exp_ins(), exp_cyc());
    else n_pass++;
  endtask

  task automatic test_timeout();
    cyc_t c; logic [10:0] obs; int cyc = 0;
    do_reset();
    void'(model_instr(0, 1'b1, 1'b1, 20, 1'b0));
    model_halt(6, 1'b0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive_cycle(c, obs);
      n_checks++;
      if (obs !== c.exp) $display("FAIL timeout_trace cyc%0d: got %b required %b", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (instr_count !== exp_ins() || cycle_count !== exp_cyc())
      $display("FAIL timeout_counts: instr=%0d cycle=%0d required %0d/%0d", instr_count, cycle_count, exp_ins(), exp_cyc());
    else n_pass++;
    do_reset();
    c.rdy = 1'b0; c.nm = 1'b0; c.st = 1'b0; c.sm = 1'b1; c.sr = 1'b0; c.exp = B_FETCH | B_REN;
    drive_cycle(c, obs);
    n_checks++;
    if (obs !== c.exp) $display("FAIL timeout_rst_clears: got %b required %b", obs, c.exp);
    else n_pass++;
  endtask

  task automatic test_step();
    cyc_t c; logic [10:0] obs; int cyc = 0;
    do_reset();
    void'(model_instr(0, 1'b0, 1'b0, 0, 1'b1));
    model_halt(3, 1'b1);
    void'(model_instr(1, 1'b0, 1'b0, 0, 1'b1));
    model_halt(2, 1'b1);
    void'(model_instr(0, 1'b1, 1'b0, 1, 1'b1));
    model_halt(4, 1'b0);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive_cycle(c, obs);
      n_checks++;
      if (obs !== c.exp) $display("FAIL step_trace cyc%0d: got %b required %b", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
    end
    n_checks++;
    if (instr_count !== exp_ins() || cycle_count !== exp_cyc())
      $display("FAIL step_counts: instr=%0d cycle=%0d required %0d/%0d", instr_count, cycle_count, exp_ins(), exp_cyc());
    else n_pass++;
  endtask

  task automatic test_reset_midwait();
    cyc_t c; logic [10:0] obs; int cyc = 0;
    do_reset();
    push(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, B_FETCH | B_REN);
    push(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, B_FETCH | B_REN);
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive_cycle(c, obs);
      n_checks++;
      if (obs !== c.exp) $display("FAIL midwait_pre cyc%0d: got %b required %b", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    m_berr = 1'b0; m_cyc = 0; m_ins = 0;
    n_checks++;
    if (cycle_count !== '0 || instr_count !== '0 || bus_error !== 1'b0)
      $display("FAIL midwait_rst: cycle=%0d instr=%0d berr=%b required 0/0/0", cycle_count, instr_count, bus_error);
    else n_pass++;
    // A full MAX_WAIT fetch must still be accepted, proving the wait counter restarted at 0.
    void'(model_instr(MAX_WAIT, 1'b0, 1'b0, 0, 1'b0));
    while (exp_q.size() > 0) begin
      c = exp_q.pop_front();
      drive_cycle(c, obs);
      n_checks++;
      if (obs !== c.exp) $display("FAIL midwait_post cyc%0d: got %b required %b", cyc, obs, c.exp);
      else n_pass++;
      cyc++;
    end
  endtask

  task automatic test_random();
    cyc_t c; logic [10:0] obs; int cyc = 0;
    int fw, mw; bit nm, st, sm, ok;
    do_reset();
    for (int k = 0; k < 50; k++) begin
      fw = ($urandom % 8 == 0) ? MAX_WAIT + 1 : int'($urandom_range(0, MAX_WAIT));
      mw = ($urandom % 8 == 0) ? MAX_WAIT + 1 : int'($urandom_range(0, MAX_WAIT));
      nm = rnd(); st = rnd(); sm = ($urandom % 4 == 0);
      ok = model_instr(fw, nm, st, mw, sm);
      if (!ok)     model_halt(3, 1'b0);
      else if (sm) model_halt(int'($urandom_range(1, 3)), 1'b1);
      while (exp_q.size() > 0) begin
        c = exp_q.pop_front();
        drive_cycle(c, obs);
        n_checks++;
        if (obs !== c.exp) $display("FAIL random_trace instr%0d cyc%0d: got %b required %b", k, cyc, obs, c.exp);
        else n_pass++;
        cyc++;
      end
      n_checks++;
      if (instr_count !== exp_ins() || cycle_count !== exp_cyc())
        $display("FAIL random_counts instr%0d: instr=%0d cycle=%0d required %0d/%0d", k, instr_count, cycle_count, exp_ins(), exp_cyc());
      else n_pass++;
      if (!ok) do_reset();
    end
  endtask

  initial begin
    test_reset();
    test_alu_run();
    test_load_wait();
    test_wait_boundary();
    test_timeout();
    test_step();
    test_reset_midwait();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/stump_sequencer.md
Name: stump_sequencer

Overview:
Parametrised successor to the Stump fixed three-phase control sequencing. It generates the fetch/execute/memory phase strobes for the Stump datapath and adds features the current core lacks:
- memory wait states via a ready handshake
- wait-state timeout with bus-error halt
- single-step debug halt
- optional performance counters
It sits between the instruction decoder (which supplies need_mem/is_store) and the datapath enables (IR load, PC increment, register/CC write).

Parameters:
MAX_WAIT, 15, max consecutive cycles mem_ready may stay low in one access before bus error; 0 disables timeout
CNT_WIDTH, 32, width of performance counters (valid range 8..64)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
mem_ready  in  1  memory has accepted the write / returned read data this cycle
need_mem  in  1  decoded: current IR is a load/store; valid only in EXECUTE
is_store  in  1  decoded: memory op is a store; valid in EXECUTE and MEMORY
step_mode  in  1  1 = halt after every completed instruction
step_req  in  1  one-cycle pulse; leaves HALT for one instruction
fetch  out  1  FETCH state
execute  out  1  EXECUTE state
memory  out  1  MEMORY state
halted  out  1  HALT state
mem_ren  out  1  memory read enable
mem_wen  out  1  memory write enable
ir_load  out  1  IR capture enable
pc_inc  out  1  PC increment writeback enable
exec_en  out  1  register/CC writeback enable for the execute phase
instr_done  out  1  one-cycle pulse when an instruction retires
bus_error  out  1  sticky timeout flag
cycle_count  out  CNT_WIDTH  cycles since reset, excluding HALT (feature-gated)
instr_count  out  CNT_WIDTH  retired instructions (feature-gated)

Behaviour:
- States: FETCH, EXECUTE, MEMORY, HALT; 2-bit registered state. Outputs are combinational decode of state and inputs.
- Reset (synchronous, rst=1 at posedge): state=FETCH, wait counter=0, bus_error=0, counters=0. In the cycle after reset, fetch=1, mem_ren=1, all other strobes 0.
- FETCH:
  - mem_ren=1.
  - If mem_ready=1: ir_load=1, pc_inc=1, next=EXECUTE.
  - Else stay in FETCH and increment the wait counter.
- EXECUTE (exactly one cycle, no memory strobes):
  - need_mem=0: exec_en=1, instr_done=1, next=(step_mode ? HALT : FETCH).
  - need_mem=1: exec_en=1 (address register capture), next=MEMORY.
- MEMORY:
  - mem_wen=is_store; mem_ren=!is_store.
  - If mem_ready=1: instr_done=1, next=(step_mode ? HALT : FETCH).
  - Else stay in MEMORY and increment the wait counter.
- HALT:
  - All strobes 0; halted=1.
  - Next=FETCH when step_req=1 or step_mode=0, provided bus_error=0.
  - With bus_error=1, HALT persists until rst.
- Wait counter:
  - Width $clog2(MAX_WAIT+1), minimum 1.
  - Cleared on every state change.
  - With MAX_WAIT>0, if mem_ready=0 in a FETCH/MEMORY cycle while the counter equals MAX_WAIT: bus_error<=1, next=HALT, no ir_load/instr_done.
  - Consequently, mem_ready arriving in wait cycle MAX_WAIT (the (MAX_WAIT+1)th cycle of the access) is still accepted.
- mem_ren and mem_wen are never both 1. Neither is ever 1 in EXECUTE or HALT.
- step_req outside HALT is ignored (not queued).
- rst has priority over every other event, including mid-wait and HALT.
- Counters wrap modulo 2^CNT_WIDTH silently.

Optional Feature:
Macro STUMP_SEQ_PERF_EN.
- Defined:
  - cycle_count increments every non-HALT cycle.
  - instr_count increments on each instr_done.
- Undefined: both outputs tied to 0 and no counter flops are synthesised.
- State/strobe behaviour is identical either way.

Test Plan:
- Reset, mem_ready=1, need_mem=0, step_mode=0 for 6 cycles -> states F,E,F,E,F,E; instr_done pulses 3 times; instr_count=3, cycle_count=6 (PERF_EN).
- Load with 2 wait states (mem_ready low 2 cycles in MEMORY, is_store=0) -> MEMORY lasts 3 cycles with mem_ren=1, mem_wen=0; instr_done on 3rd cycle; total instruction 5 cycles.
- Store, MAX_WAIT=3, mem_ready held 0 -> 4 MEMORY cycles, then bus_error=1, halted=1; step_req and step_mode=0 do not leave HALT; rst clears to FETCH.
- step_mode=1, ALU op -> HALT after EXECUTE; step_req pulse -> exactly one F,E sequence, back to HALT; instr_count +1 per step_req.
- Assert rst during a FETCH wait (counter=2) -> next cycle FETCH, counter=0, bus_error=0, counters=0.
- Run with STUMP_SEQ_PERF_EN undefined -> cycle_count=instr_count=0 throughout; strobe trace matches the first scenario exactly.
